// File: rtl/zc_pkg.sv
// rtl/zc_pkg.sv - shared state encodings and saturation limits for the zero-crossing blocks
package zc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        P_HALF = 2'b01,
        N_HALF = 2'b10
    } zc_state_t;

    // Largest value representable in a signed word of the given width.
    function automatic longint SAT_MAX(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed word of the given width.
    function automatic longint SAT_MIN(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/zc_sat_addsub.sv
// rtl/zc_sat_addsub.sv - combinational saturating offset +/- amplitude
//  offset    in   WIDTH  signed DC level
//  amplitude in   WIDTH  signed peak deviation
//  subtract  in   1      0: offset + amplitude, 1: offset - amplitude
//  result    out  WIDTH  clipped to the signed WIDTH range
module zc_sat_addsub
    import zc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] offset,
    input  logic signed [WIDTH-1:0] amplitude,
    input  logic                    subtract,
    output logic signed [WIDTH-1:0] result
);

    localparam logic signed [WIDTH:0] MAX_V = (WIDTH + 1)'(SAT_MAX(WIDTH));
    localparam logic signed [WIDTH:0] MIN_V = (WIDTH + 1)'(SAT_MIN(WIDTH));

    logic signed [WIDTH:0] off_w;
    logic signed [WIDTH:0] amp_w;
    logic signed [WIDTH:0] wide;

    // One extra bit holds any sum or difference of two WIDTH-bit operands exactly.
    always_comb begin
        off_w = {offset[WIDTH-1], offset};
        amp_w = {amplitude[WIDTH-1], amplitude};
        wide  = subtract ? (off_w - amp_w) : (off_w + amp_w);
        if (wide > MAX_V) begin
            result = MAX_V[WIDTH-1:0];
        end else if (wide < MIN_V) begin
            result = MIN_V[WIDTH-1:0];
        end else begin
            result = wide[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/zero_crossing_gen.sv
// rtl/zero_crossing_gen.sv - square-wave sample source with programmed zero-crossing intervals
//  clk, reset, clear      clock, sync active-high reset, sync soft clear
//  enable                 run control, sampled in IDLE and at half-period boundaries
//  amplitude, offset      signed level controls
//  start_polarity         0: first half positive, 1: first half negative
//  i_tdata/i_tvalid/i_tlast/i_tready   half-period length stream
//  o_tdata/o_tvalid/o_tlast/o_tready   signed sample stream
//  pps                    asynchronous pulse-per-second
//  cycles_per_sec         full cycles in the last complete PPS interval
//  underflow              sticky: no usable length at a boundary, previous length reused
module zero_crossing_gen
    import zc_pkg::*;
#(
    parameter int COUNTER_SIZE = 32,
    parameter int WIDTH        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] amplitude,
    input  logic signed [WIDTH-1:0] offset,
    input  logic                    start_polarity,
    input  logic [COUNTER_SIZE-1:0] i_tdata,
    input  logic                    i_tvalid,
    input  logic                    i_tlast,
    output logic                    i_tready,
    output logic signed [WIDTH-1:0] o_tdata,
    output logic                    o_tvalid,
    output logic                    o_tlast,
    input  logic                    o_tready,
    input  logic                    pps,
    output logic [COUNTER_SIZE-1:0] cycles_per_sec,
    output logic                    underflow
);

    localparam logic [COUNTER_SIZE-1:0] ONE = COUNTER_SIZE'(1);

    zc_state_t               state, state_next;
    logic [COUNTER_SIZE-1:0] remaining, remaining_next;
    logic [COUNTER_SIZE-1:0] half_len, half_len_next;
    logic                    last_flag, last_flag_next;
    logic [COUNTER_SIZE-1:0] count;
    logic                    set_underflow;
    logic                    cycle_inc;
    logic                    soft_reset;
    logic                    pps_meta, pps_sync, pps_prev;
    logic                    pps_edge;
    logic signed [WIDTH-1:0] sample;

    assign soft_reset = reset | clear;
    assign pps_edge   = pps_sync & ~pps_prev;

    zc_sat_addsub #(
        .WIDTH(WIDTH)
    ) u_sat (
        .offset   (offset),
        .amplitude(amplitude),
        .subtract (state == N_HALF),
        .result   (sample)
    );

    always_ff @(posedge clk) begin
        if (soft_reset) begin
            state     <= IDLE;
            remaining <= '0;
            half_len  <= '0;
            last_flag <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            half_len  <= half_len_next;
            last_flag <= last_flag_next;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        half_len_next  = half_len;
        last_flag_next = last_flag;
        set_underflow  = 1'b0;
        i_tready       = 1'b0;
        o_tvalid       = 1'b0;
        o_tlast        = 1'b0;
        o_tdata        = '0;
        case (state)
            IDLE: begin
                i_tready = enable;
                // A zero-length word is accepted and dropped; nothing is generated for it.
                if (enable && i_tvalid && (i_tdata != '0)) begin
                    remaining_next = i_tdata;
                    half_len_next  = i_tdata;
                    last_flag_next = i_tlast;
                    state_next     = start_polarity ? N_HALF : P_HALF;
                end
            end
            P_HALF, N_HALF: begin
                o_tvalid = 1'b1;
                o_tdata  = sample;
                o_tlast  = last_flag && (remaining == ONE);
                if (o_tready) begin
                    if (remaining != ONE) begin
                        remaining_next = remaining - ONE;
                    end else if (last_flag || !enable) begin
                        state_next = IDLE;
                    end else begin
                        // Seamless boundary: the next half starts on the very next sample,
                        // so a missing or unusable length repeats the previous one.
                        i_tready   = 1'b1;
                        state_next = (state == P_HALF) ? N_HALF : P_HALF;
                        if (i_tvalid && (i_tdata != '0)) begin
                            remaining_next = i_tdata;
                            half_len_next  = i_tdata;
                            last_flag_next = i_tlast;
                        end else begin
                            remaining_next = half_len;
                            last_flag_next = 1'b0;
                            set_underflow  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Reset/clear cut the stream off in the cycle they are asserted, with no handshakes.
        if (soft_reset) begin
            i_tready = 1'b0;
            o_tvalid = 1'b0;
            o_tlast  = 1'b0;
            o_tdata  = '0;
        end
    end

    assign cycle_inc = (state == N_HALF) && (state_next == P_HALF) && !soft_reset;

    always_ff @(posedge clk) begin
        if (soft_reset) begin
            underflow      <= 1'b0;
            count          <= '0;
            cycles_per_sec <= '0;
            pps_meta       <= 1'b0;
            pps_sync       <= 1'b0;
            pps_prev       <= 1'b0;
        end else begin
            if (set_underflow) begin
                underflow <= 1'b1;
            end
            pps_meta <= pps;
            pps_sync <= pps_meta;
            pps_prev <= pps_sync;
            // A cycle completing on the edge itself belongs to the interval being closed.
            if (pps_edge) begin
                cycles_per_sec <= count + COUNTER_SIZE'(cycle_inc);
                count          <= '0;
            end else begin
                count <= count + COUNTER_SIZE'(cycle_inc);
            end
        end
    end

endmodule

// File: tb/tb_zero_crossing_gen.sv
// tb/tb_zero_crossing_gen.sv - self-checking bench for zero_crossing_gen
module tb_zero_crossing_gen;

    localparam int CS = 32;
    localparam int W  = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clear;
    logic                 enable;
    logic signed [W-1:0]  amplitude;
    logic signed [W-1:0]  offset;
    logic                 start_polarity;
    logic [CS-1:0]        i_tdata;
    logic                 i_tvalid;
    logic                 i_tlast;
    logic                 i_tready;
    logic signed [W-1:0]  o_tdata;
    logic                 o_tvalid;
    logic                 o_tlast;
    logic                 o_tready;
    logic                 pps;
    logic [CS-1:0]        cycles_per_sec;
    logic                 underflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int first_acc;
    int first_out;

    int unsigned in_len[$];
    bit          in_last[$];
    int          exp_data[$];
    bit          exp_last[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zero_crossing_gen #(
        .COUNTER_SIZE(CS),
        .WIDTH       (W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .enable        (enable),
        .amplitude     (amplitude),
        .offset        (offset),
        .start_polarity(start_polarity),
        .i_tdata       (i_tdata),
        .i_tvalid      (i_tvalid),
        .i_tlast       (i_tlast),
        .i_tready      (i_tready),
        .o_tdata       (o_tdata),
        .o_tvalid      (o_tvalid),
        .o_tlast       (o_tlast),
        .o_tready      (o_tready),
        .pps           (pps),
        .cycles_per_sec(cycles_per_sec),
        .underflow     (underflow)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Expected accepted-sample stream: each length gives that many samples at one level,
    // levels alternate, and a burst end restarts the alternation at the start polarity.
    task automatic build_expected(input bit sp);
        bit neg = sp;
        int amp = int'(amplitude);
        int off = int'(offset);
        exp_data.delete();
        exp_last.delete();
        foreach (in_len[i]) begin
            for (int k = 0; k < int'(in_len[i]); k++) begin
                exp_data.push_back(sat(neg ? off - amp : off + amp));
                exp_last.push_back(in_last[i] && (k == int'(in_len[i]) - 1));
            end
            neg = in_last[i] ? sp : !neg;
        end
    endtask

    task automatic drive_input();
        i_tvalid = (in_len.size() > 0);
        i_tdata  = i_tvalid ? CS'(in_len[0]) : '0;
        i_tlast  = i_tvalid ? in_last[0] : 1'b0;
    endtask

    task automatic run_burst(input string tag, input int budget, input int ready_pct);
        int n = 0;
        first_acc = -1;
        first_out = -1;
        build_expected(start_polarity);
        while ((exp_data.size() > 0) && (n < budget)) begin
            @(negedge clk);
            o_tready = ($urandom_range(99) < ready_pct);
            drive_input();
            #1;
            if (i_tvalid && i_tready) begin
                if (first_acc < 0) first_acc = cyc;
                void'(in_len.pop_front());
                void'(in_last.pop_front());
            end
            if (o_tvalid && o_tready) begin
                if (first_out < 0) first_out = cyc;
                check({tag, "_data"}, o_tdata, exp_data.pop_front());
                check({tag, "_last"}, o_tlast, exp_last.pop_front());
            end
            n++;
        end
        check({tag, "_remaining_samples"}, exp_data.size(), 0);
        @(negedge clk);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        o_tready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int ns;
        bit stopped;
        int seen;

        reset          = 1'b1;
        clear          = 1'b0;
        enable         = 1'b1;
        amplitude      = 16'sd1000;
        offset         = 16'sd0;
        start_polarity = 1'b0;
        i_tdata        = '0;
        i_tvalid       = 1'b0;
        i_tlast        = 1'b0;
        o_tready       = 1'b1;
        pps            = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tlast", o_tlast, 0);
        check("rst_o_tdata", o_tdata, 0);
        check("rst_i_tready", i_tready, 0);
        check("rst_underflow", underflow, 0);
        check("rst_cycles_per_sec", cycles_per_sec, 0);
        reset = 1'b0;

        // Three 4-sample halves ending a burst
        in_len  = '{4, 4, 4};
        in_last = '{0, 0, 1};
        run_burst("t1", 100, 100);
        check("t1_first_sample_latency", first_out - first_acc, 1);
        #1;
        check("t1_idle_o_tvalid", o_tvalid, 0);
        check("t1_idle_i_tready", i_tready, 1);
        check("t1_underflow", underflow, 0);

        // Single length 3 then starve: halves keep alternating with the reused length
        do_reset();
        in_len  = '{3};
        in_last = '{0};
        ns = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            drive_input();
            #1;
            if (i_tvalid && i_tready) begin
                void'(in_len.pop_front());
                void'(in_last.pop_front());
            end
            if (o_tvalid && o_tready) begin
                check("t2_data", o_tdata, ((ns / 3) % 2) ? -1000 : 1000);
                check("t2_underflow", underflow, (ns >= 3));
                ns++;
            end
        end
        i_tvalid = 1'b0;
        check("t2_sample_count", ns, 29);
        enable  = 1'b0;
        stopped = 1'b0;
        for (int k = 0; k < 10 && !stopped; k++) begin
            @(negedge clk);
            #1;
            if (!o_tvalid) stopped = 1'b1;
            else ns++;
        end
        check("t2_stopped", stopped, 1);
        check("t2_stop_on_boundary", ns % 3, 0);
        check("t2_underflow_sticky", underflow, 1);
        enable = 1'b1;

        // Saturation at both rails
        do_reset();
        amplitude = 16'sd20000;
        offset    = 16'sd20000;
        in_len    = '{2, 2};
        in_last   = '{0, 1};
        run_burst("t3_hi", 50, 100);
        offset  = -16'sd20000;
        in_len  = '{2, 2};
        in_last = '{0, 1};
        run_burst("t3_lo", 50, 100);

        // Random lengths, levels and back-pressure
        for (int r = 0; r < 3; r++) begin
            do_reset();
            amplitude      = W'($urandom_range(65535));
            offset         = W'($urandom_range(65535));
            start_polarity = $urandom_range(1);
            in_len.delete();
            in_last.delete();
            for (int i = 0; i < 12; i++) begin
                in_len.push_back($urandom_range(6, 1));
                in_last.push_back((i == 11) || ($urandom_range(4) == 0));
            end
            run_burst("t4", 2000, 50);
        end

        // PPS: 100 cycles between edges with a 10-sample full cycle always gives 10,
        // swept over every phase so one edge lands on an N->P transition.
        do_reset();
        amplitude      = 16'sd1000;
        offset         = 16'sd0;
        start_polarity = 1'b0;
        @(negedge clk);
        i_tvalid = 1'b1;
        i_tdata  = 32'd5;
        i_tlast  = 1'b0;
        @(negedge clk);
        i_tvalid = 1'b0;
        repeat (5) @(negedge clk);
        for (int p = 0; p < 10; p++) begin
            pps = 1'b1;
            repeat (3) @(negedge clk);
            pps = 1'b0;
            repeat (97) @(negedge clk);
            pps = 1'b1;
            repeat (3) @(negedge clk);
            pps = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            check("t5_cycles_per_sec", cycles_per_sec, 10);
            repeat (p + 1) @(negedge clk);
        end

        // Clear mid-half: output stops at once and all counters/flags drop
        #1;
        check("t6_running_before_clear", o_tvalid, 1);
        check("t6_underflow_before_clear", underflow, 1);
        clear = 1'b1;
        #1;
        check("t6_o_tvalid_during_clear", o_tvalid, 0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("t6_o_tvalid_after_clear", o_tvalid, 0);
        check("t6_cycles_per_sec", cycles_per_sec, 0);
        check("t6_underflow", underflow, 0);
        check("t6_i_tready", i_tready, 1);

        // Zero-length word in IDLE is swallowed without output
        @(negedge clk);
        i_tvalid = 1'b1;
        i_tdata  = '0;
        #1;
        check("t6_zero_accepted", i_tready, 1);
        @(negedge clk);
        i_tvalid = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (o_tvalid) seen++;
        end
        check("t6_zero_no_output", seen, 0);
        in_len  = '{2};
        in_last = '{1};
        run_burst("t6_after_zero", 20, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
